// File: rtl/fifo_block_packer_if.sv
// fifo_block_packer_if: FIFO read port, flush and block handshake bundle for fifo_block_packer.
interface fifo_block_packer_if #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WORDS = 4
);
    localparam int CNT_W = $clog2(BLOCK_WORDS + 1);
    logic                         fifo_empty;
    logic                         fifo_rd_en;
    logic [WIDTH-1:0]             fifo_rd_data;
    logic                         flush;
    logic [WIDTH*BLOCK_WORDS-1:0] blk_data;
    logic [CNT_W-1:0]             blk_nwords;
    logic                         blk_valid;
    logic                         blk_ready;
    logic                         busy;
    modport master (
        input  fifo_empty, fifo_rd_data, flush, blk_ready,
        output fifo_rd_en, blk_data, blk_nwords, blk_valid, busy
    );
    modport slave (
        output fifo_empty, fifo_rd_data, flush, blk_ready,
        input  fifo_rd_en, blk_data, blk_nwords, blk_valid, busy
    );
endinterface

// File: rtl/fifo_block_packer.sv
// fifo_block_packer: pops FIFO words and packs BLOCK_WORDS of them into one block with flush padding.
module fifo_block_packer #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WORDS = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_block_packer_if.master bus
);
    localparam int CNT_W = $clog2(BLOCK_WORDS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BLOCK_WORDS);

    typedef enum logic [1:0] {FILL, DRAIN, OUT} state_t;

    state_t                             state_q, state_d;
    logic [CNT_W-1:0]                   issued_q, issued_d, captured_q, captured_d;
    logic                               flush_pend_q, flush_pend_d, rd_vld_q, rd_vld_d;
    logic [BLOCK_WORDS-1:0][WIDTH-1:0]  slot_q, slot_d;
    logic                               rd_en;

    assign rd_en = state_q == FILL && !bus.fifo_empty && issued_q < FULL && !flush_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            issued_q     <= '0;
            captured_q   <= '0;
            flush_pend_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            slot_q       <= '0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            captured_q   <= captured_d;
            flush_pend_q <= flush_pend_d;
            rd_vld_q     <= rd_vld_d;
            slot_q       <= slot_d;
        end
    end

    // Read data lands one cycle after its strobe, always into the next free slot.
    always_comb begin
        rd_vld_d     = rd_en;
        issued_d     = issued_q + CNT_W'(rd_en);
        captured_d   = captured_q + CNT_W'(rd_vld_q);
        slot_d       = slot_q;
        for (int i = 0; i < BLOCK_WORDS; i++)
            if (rd_vld_q && captured_q == CNT_W'(i)) slot_d[i] = bus.fifo_rd_data;
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            FILL: begin
                if (issued_d == FULL) begin
                    state_d      = DRAIN;
                    flush_pend_d = 1'b0;
                end else if (flush_pend_q && !rd_vld_q) begin
                    state_d      = captured_q != '0 ? OUT : FILL;
                    flush_pend_d = captured_q != '0;
                end else begin
                    flush_pend_d = flush_pend_q || bus.flush;
                end
            end
            DRAIN: state_d = captured_d == issued_q ? OUT : DRAIN;
            OUT: begin
                if (bus.blk_ready) begin
                    state_d      = FILL;
                    issued_d     = '0;
                    captured_d   = '0;
                    flush_pend_d = 1'b0;
                    slot_d       = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        bus.fifo_rd_en = rd_en;
        bus.blk_valid  = state_q == OUT;
        bus.blk_nwords = state_q == OUT ? captured_q : '0;
        bus.blk_data   = slot_q;
        bus.busy       = state_q != FILL || captured_q != '0 || rd_vld_q;
    end
endmodule

// File: tb/tb_fifo_block_packer.sv
// tb_fifo_block_packer: scoreboard bench with a FIFO model and a word-stream block reference model.
module tb_fifo_block_packer;
    localparam int W  = 32;
    localparam int BW = 4;

    typedef struct {
        logic [W*BW-1:0] data;
        logic [2:0]      n;
    } blk_t;

    logic clk, rst, rand_ready;
    int   checks, errors;
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] pend[$];
    blk_t         exp_q[$];

    fifo_block_packer_if #(.WIDTH(W), .BLOCK_WORDS(BW)) bus ();
    fifo_block_packer #(.WIDTH(W), .BLOCK_WORDS(BW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W*BW-1:0] got, input logic [W*BW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Reference model: the word stream is cut into blocks of BW; a flush closes a non-empty remainder.
    task automatic model_emit();
        blk_t b;
        b.data = '0;
        b.n    = 3'(pend.size());
        for (int i = 0; i < pend.size(); i++) b.data[i*W +: W] = pend[i];
        exp_q.push_back(b);
        pend.delete();
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
        pend.push_back(w);
        if (pend.size() == BW) model_emit();
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        if (pend.size() > 0) model_emit();
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(nm, k < 300, 1);
    endtask

    // FIFO model: strobe sampled just before the edge, data presented just after it.
    initial begin
        logic p;
        forever begin
            @(negedge clk);
            #4;
            p = bus.fifo_rd_en;
            @(posedge clk);
            #1;
            if (p && fifo_q.size() > 0) begin
                bus.fifo_rd_data = fifo_q.pop_front();
                bus.fifo_empty   = fifo_q.size() == 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_ready) bus.blk_ready = $urandom_range(0, 3) != 0;
    end

    // Monitor: pops the scoreboard on every accepted block and polices hold/read rules.
    initial begin
        logic stall;
        blk_t hold, e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) stall = 1'b0;
            else begin
                if (stall) begin
                    chk("hold_valid", bus.blk_valid, 1);
                    chk("hold_data", bus.blk_data, hold.data);
                    chk("hold_nwords", bus.blk_nwords, hold.n);
                end
                if (bus.fifo_rd_en) chk("rd_gate", bus.fifo_empty || bus.blk_valid, 0);
                if (bus.blk_valid && bus.blk_ready) begin
                    if (exp_q.size() == 0) chk("extra_blk", bus.blk_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("blk_data", bus.blk_data, e.data);
                        chk("blk_nwords", bus.blk_nwords, e.n);
                    end
                end
                stall     = bus.blk_valid && !bus.blk_ready;
                hold.data = bus.blk_data;
                hold.n    = bus.blk_nwords;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rmask, vmask;
        blk_t       dropped;
        int         k, n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rand_ready = 1'b0;
        bus.blk_ready = 1'b0;
        bus.flush = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.blk_valid, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_nwords", bus.blk_nwords, 0);
        chk("rst_data", bus.blk_data, 0);
        rst = 1'b0;
        bus.blk_ready = 1'b1;

        // Preloaded full block: four back-to-back reads, valid five cycles after the first.
        @(negedge clk);
        for (int i = 0; i < BW; i++) push_word(32'hA0A0_0000 + i);
        #1;
        rmask = '0;
        vmask = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            rmask[i] = bus.fifo_rd_en;
            vmask[i] = bus.blk_valid;
        end
        chk("lat_rd_en", rmask, 8'h0F);
        chk("lat_valid", vmask, 8'h20);
        wait_idle("idle_full");

        // Trickle with three idle cycles between words.
        for (int i = 0; i < BW; i++) begin
            @(negedge clk);
            push_word(32'hA1A1_0000 + i);
            repeat (3) @(negedge clk);
        end
        wait_idle("idle_trickle");

        // Partial flush, then an empty flush.
        @(negedge clk);
        push_word(32'hB0B0_0000);
        push_word(32'hB0B0_0001);
        repeat (4) @(negedge clk);
        chk("partial_busy", bus.busy, 1);
        pulse_flush();
        wait_idle("idle_partial");
        pulse_flush();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("empty_flush_valid", bus.blk_valid, 0);
            chk("empty_flush_busy", bus.busy, 0);
        end

        // Back-pressure with two blocks queued.
        bus.blk_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2 * BW; i++) push_word(32'hC0C0_0000 + i);
        repeat (10) @(negedge clk);
        chk("bp_valid", bus.blk_valid, 1);
        chk("bp_fifo_left", fifo_q.size(), BW);
        bus.blk_ready = 1'b1;
        @(negedge clk);
        k = 1;
        while (!bus.blk_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("bp_second_lat", k, 6);
        wait_idle("idle_bp");

        // Reset while draining with three words captured.
        @(negedge clk);
        for (int i = 0; i < BW; i++) push_word(32'hD0D0_0000 + i);
        repeat (4) @(negedge clk);
        chk("drain_busy", bus.busy, 1);
        chk("drain_rd_en", bus.fifo_rd_en, 0);
        rst = 1'b1;
        dropped = exp_q.pop_back();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", bus.blk_valid, 0);
        chk("mid_rst_rd_en", bus.fifo_rd_en, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_nwords", bus.blk_nwords, 0);
        chk("mid_rst_data", bus.blk_data, 0);
        @(negedge clk);
        for (int i = 0; i < BW; i++) push_word(32'hE0E0_0000 + i);
        wait_idle("idle_post_rst");

        // Flush coinciding with the final read issue is dropped.
        @(negedge clk);
        for (int i = 0; i < BW; i++) push_word(32'hF0F0_0000 + i);
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_on_last_rd", bus.fifo_rd_en, 1);
        @(negedge clk);
        bus.flush = 1'b0;
        wait_idle("idle_flush_last");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_extra_partial", bus.blk_valid, 0);
        end

        // Randomized episodes: bursts with gaps, random back-pressure, flush of any remainder.
        rand_ready = 1'b1;
        for (int ep = 0; ep < 40; ep++) begin
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                push_word($urandom);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            k = 0;
            while (fifo_q.size() != 0 && k < 300) begin
                @(negedge clk);
                k++;
            end
            repeat (3) @(negedge clk);
            if (pend.size() > 0 || $urandom_range(0, 3) == 0) pulse_flush();
            wait_idle("idle_random");
        end
        rand_ready = 1'b0;
        bus.blk_ready = 1'b1;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_block_packer.md
Name: fifo_block_packer

Overview:
- Downstream consumer of the word FIFO. Pops WIDTH-bit words through the FIFO read port and packs BLOCK_WORDS consecutive words into one wide block.
- Presents each block to the next stage (crypto core / bus master) with a valid/ready handshake.
- Supports a flush that emits a partial, zero-padded block.
- Sits between the fifo_buffer read side and any block-oriented consumer.

Parameters:
- WIDTH, 32, FIFO word width in bits.
- BLOCK_WORDS, 4, words per output block (>=2).
- CNT_W, $clog2(BLOCK_WORDS+1), width of word counters (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous, active-high.
- fifo_empty  input  1  FIFO empty flag; combinational from FIFO pointers.
- fifo_rd_en  output  1  FIFO read strobe; one pop per cycle high.
- fifo_rd_data  input  WIDTH  FIFO read data, valid one cycle after fifo_rd_en.
- flush  input  1  pulse: emit the partially filled block.
- blk_data  output  WIDTH*BLOCK_WORDS  packed block; word 0 at bits [WIDTH-1:0].
- blk_nwords  output  CNT_W  number of valid words in blk_data.
- blk_valid  output  1  block available.
- blk_ready  input  1  consumer accepts block.
- busy  output  1  high when not in FILL with zero words captured.

Behaviour:
- Reset: all outputs 0, including blk_data, blk_nwords, blk_valid, fifo_rd_en and busy. State FILL. Counters issued=0, captured=0. flush_pend=0. Reset overrides every other event, including mid-block and mid-handshake; the partial block is discarded.
- States: FILL, DRAIN, OUT.
- FILL:
  - fifo_rd_en = !fifo_empty && issued < BLOCK_WORDS && !flush_pend. This is a combinational output; reads may be issued back-to-back every cycle.
  - Each cycle with fifo_rd_en high: issued++.
  - Cycle after each read: rd_vld=1. fifo_rd_data is written into slot captured, then captured++.
  - When the read that makes issued==BLOCK_WORDS is issued, go to DRAIN.
- DRAIN:
  - fifo_rd_en=0.
  - When captured reaches issued, go to OUT, with blk_valid=1 the next cycle and blk_nwords=captured.
- Flush:
  - flush sampled in FILL sets flush_pend, which blocks further reads.
  - When flush_pend=1 and no read is in flight (rd_vld=0): if captured>0, go to OUT; if captured==0, clear flush_pend and stay in FILL (empty flush is ignored, no block emitted).
  - flush in DRAIN or OUT is ignored.
  - flush in the same cycle as the final read issue: the full block is emitted and the flush is dropped.
- OUT:
  - blk_valid=1. blk_data and blk_nwords are held stable until blk_ready.
  - fifo_rd_en=0.
  - On blk_valid && blk_ready: next cycle blk_valid=0, blk_data cleared to 0, counters=0, flush_pend=0, state FILL. Reading may restart in that same FILL cycle.
- Padding: unused slots in a partial block read as 0.
- Latency: a full block that is resident in the FIFO reaches blk_valid BLOCK_WORDS+1 cycles after the first fifo_rd_en.
- Back-pressure: blk_ready low holds OUT indefinitely with no FIFO reads. The FIFO may fill, and the upstream writer sees the FIFO's own full handling.
- fifo_empty going high mid-block pauses issuing without losing words. Words already issued are still captured.
- busy = (state!=FILL) || captured!=0 || rd_vld.

Test Plan:
- Reset then 4 words A0..A3 preloaded, blk_ready=1 -> fifo_rd_en high 4 consecutive cycles; blk_valid on cycle 5; blk_data={A3,A2,A1,A0}; blk_nwords=4; 1-cycle valid pulse.
- Words trickle in with gaps (fifo_empty toggling, 3 idle cycles between words) -> no read while empty; block is still {A3..A0} in order; blk_valid is only asserted after the 4th capture.
- 2 words B0,B1 captured, then flush pulse -> blk_valid with blk_data={0,0,B1,B0}, blk_nwords=2. flush with 0 words captured -> no blk_valid, busy stays 0.
- blk_ready held low 10 cycles with 8 words queued -> blk_data is stable; fifo_rd_en=0 throughout; after blk_ready=1 the second block follows 5 cycles later with correct order.
- rst asserted while in DRAIN with 3 words captured -> next cycle all outputs 0, state FILL; the subsequent block contains only post-reset words.
- flush in the same cycle as the 4th read issue -> single full block, nwords=4, no extra partial block emitted.
